lu_entry_composer: RTL and testbench
====================================

Name: lu_entry_composer

Overview:
- Sits directly downstream of the data-link/ARP/IP header parser and upstream of the flow-table lookup stage.
- Latches the L2 fields on dl_done, then waits for the matching L3 result (arp_done or ip_tp_done) as selected by ethtype.
- Packs all fields into one fixed 256-bit lookup key and issues it with a valid/ready handshake.
- Pulses compose_done back to the parser so the parser can release its next packet.

Parameters:
- C_AXIS_LEN_DATA_WIDTH, 16, packet length width.
- C_AXIS_SPT_DATA_WIDTH, 8, source-port width; the key layout below is defined for 8.
- L3_TIMEOUT, 64, cycles to wait in WAIT_L3 before composing with zeroed L3 fields; legal range 2..65535.

Ports:
- asclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- dl_done  in  1  one-cycle strobe; all dl_* inputs, pkt_len and src_port are valid in this cycle.
- pkt_len  in  16  packet length in bytes.
- src_port  in  8  ingress port.
- dl_dst, dl_src  in  48 each  MAC addresses.
- dl_ethtype  in  16  ethtype (post-VLAN).
- dl_vlantag  in  16  VLAN TCI; 0 if untagged.
- arp_done  in  1  strobe; arp_op, arp_ip_src, arp_ip_dst are valid in this cycle.
- arp_op  in  8; arp_ip_src, arp_ip_dst  in  32 each.
- ip_tp_done  in  1  strobe; ip_tos, ip_proto, ip_src, ip_dst are valid in this cycle.
- ip_tos  in  6; ip_proto  in  8; ip_src, ip_dst  in  32 each.
- compose_done  out  1  one-cycle pulse to the parser.
- lu_req_valid  out  1  lookup key valid.
- lu_req_ready  in  1  lookup stage accepts the key.
- lu_entry  out  256  packed lookup key.
- lu_pkt_len  out  16  packet length travelling with the key.
- entry_cnt, drop_cnt, timeout_cnt  out  32 each  statistics counters.

Behaviour:
- Reset:
  - Asynchronous; asserts immediately, including mid-operation.
  - State returns to IDLE.
  - All outputs and counters go to 0; any partially built entry is discarded.
- Key layout, MSB first:
  - [255:248] src_port; [247:200] dl_dst; [199:152] dl_src; [151:136] dl_ethtype; [135:120] dl_vlantag.
  - [119:114] tos; [113:106] proto; [105:74] nw_src; [73:42] nw_dst; [41:0] zero.
- L3 field source:
  - IP: tos/proto/nw_src/nw_dst come from ip_tos/ip_proto/ip_src/ip_dst.
  - ARP: tos=0, proto=arp_op, nw_src=arp_ip_src, nw_dst=arp_ip_dst.
  - Other ethtypes, or after a timeout: all four fields are 0.
- State machine (one-hot): IDLE, WAIT_L3, OUTPUT, DONE.
- IDLE, on dl_done, latch the L2 fields and pkt_len, then branch on dl_ethtype:
  - 0x0800: go to WAIT_L3 expecting IP. If ip_tp_done is high in the same cycle, also latch the L3 fields and go straight to OUTPUT.
  - 0x0806: same rule, expecting ARP and using arp_done.
  - Any other value: go to OUTPUT with zeroed L3 fields.
- WAIT_L3:
  - The timeout counter starts at 0 on entry and increments every cycle.
  - The expected strobe latches the L3 fields and moves to OUTPUT.
  - The non-expected strobe is ignored.
  - When the counter reaches L3_TIMEOUT-1 without the expected strobe: go to OUTPUT with zeroed L3 fields and increment timeout_cnt.
- OUTPUT:
  - lu_req_valid=1.
  - lu_entry and lu_pkt_len are registered and held stable until lu_req_ready.
  - On the handshake (valid & ready): increment entry_cnt, go to DONE.
- DONE: compose_done=1 for exactly one cycle, lu_req_valid=0, then go to IDLE.
- Latency:
  - Non-IP/ARP packet: dl_done at cycle T gives lu_req_valid at T+1.
  - IP/ARP packet: L3 strobe at cycle U gives lu_req_valid at U+1.
  - Handshake at cycle H gives compose_done at H+1.
  - Back-to-back throughput is one packet per 3 cycles.
- Boundary conditions:
  - dl_done while not in IDLE: dropped and drop_cnt increments; the entry in progress is unaffected.
  - arp_done or ip_tp_done in IDLE without dl_done: ignored.
  - lu_req_ready high outside OUTPUT: no effect.
  - Counters wrap from 0xFFFFFFFF to 0.
- All outputs are registered; there is no combinational path from lu_req_ready to lu_req_valid.

Decomposition:
- Shared package:
  - Ethtype constants: ETH_IPV4=16'h0800, ETH_ARP=16'h0806.
  - Key field bit-position localparams.
  - LU_ENTRY_WIDTH=256.
  - Composer state encodings.
- Sub-module: none required. Optionally factor out a small lu_key_pack that combinationally packs the fields, so that the lookup stage can reuse the layout.

Test Plan:
- IPv4 path: dl_done with ethtype 0x0800, src_port 3, dl_dst 00:11:22:33:44:55, vlantag 0; ip_tp_done 5 cycles later with tos 0x2E, proto 6, src 10.0.0.1, dst 10.0.0.2; ready tied high -> lu_entry[113:106]=0x06, [105:74]=0x0A000001, [255:248]=0x03; valid one cycle after ip_tp_done; compose_done one cycle later; entry_cnt=1.
- ARP path with backpressure: ethtype 0x0806, arp_done with op 1, then ready held low for 10 cycles -> valid stays high with lu_entry unchanged and proto field 0x01; compose_done exactly one cycle after ready rises.
- Non-IP packet: ethtype 0x86DD -> valid at T+1 with bits [119:42]=0.
- Timeout and drop: ethtype 0x0800 with no ip_tp_done -> after 64 cycles the entry has zero L3 fields and timeout_cnt=1. A second dl_done during WAIT_L3 -> drop_cnt=1 and the first entry's L2 fields are unchanged.
- Simultaneous strobes and reset: dl_done and ip_tp_done in the same cycle -> valid the next cycle with the IP fields. aresetn low during OUTPUT -> valid and counters go to 0 immediately, with no compose_done.

Source files
------------

// File: rtl/lu_entry_composer_pkg.sv
// Shared definitions for the lookup-key composer: ethtypes, key layout and FSM states.
package lu_entry_composer_pkg;

  localparam int unsigned LU_ENTRY_WIDTH = 256;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_ARP  = 16'h0806;

  localparam int unsigned KEY_SPT_MSB    = 255;
  localparam int unsigned KEY_SPT_LSB    = 248;
  localparam int unsigned KEY_DLDST_MSB  = 247;
  localparam int unsigned KEY_DLDST_LSB  = 200;
  localparam int unsigned KEY_DLSRC_MSB  = 199;
  localparam int unsigned KEY_DLSRC_LSB  = 152;
  localparam int unsigned KEY_ETYPE_MSB  = 151;
  localparam int unsigned KEY_ETYPE_LSB  = 136;
  localparam int unsigned KEY_VLAN_MSB   = 135;
  localparam int unsigned KEY_VLAN_LSB   = 120;
  localparam int unsigned KEY_TOS_MSB    = 119;
  localparam int unsigned KEY_TOS_LSB    = 114;
  localparam int unsigned KEY_PROTO_MSB  = 113;
  localparam int unsigned KEY_PROTO_LSB  = 106;
  localparam int unsigned KEY_NWSRC_MSB  = 105;
  localparam int unsigned KEY_NWSRC_LSB  = 74;
  localparam int unsigned KEY_NWDST_MSB  = 73;
  localparam int unsigned KEY_NWDST_LSB  = 42;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_WAIT_L3 = 4'b0010,
    ST_OUTPUT  = 4'b0100,
    ST_DONE    = 4'b1000
  } composer_state_e;

endpackage

// File: rtl/lu_entry_composer_key_pack.sv
// Combinational packer for the 256-bit lookup key; reusable by the lookup stage.
module lu_entry_composer_key_pack
  import lu_entry_composer_pkg::*;
(
  input  logic [7:0]                i_src_port,
  input  logic [47:0]               i_dl_dst,
  input  logic [47:0]               i_dl_src,
  input  logic [15:0]               i_dl_ethtype,
  input  logic [15:0]               i_dl_vlantag,
  input  logic [5:0]                i_tos,
  input  logic [7:0]                i_proto,
  input  logic [31:0]               i_nw_src,
  input  logic [31:0]               i_nw_dst,
  output logic [LU_ENTRY_WIDTH-1:0] o_key
);

  always_comb begin
    o_key = '0;
    o_key[KEY_SPT_MSB:KEY_SPT_LSB]     = i_src_port;
    o_key[KEY_DLDST_MSB:KEY_DLDST_LSB] = i_dl_dst;
    o_key[KEY_DLSRC_MSB:KEY_DLSRC_LSB] = i_dl_src;
    o_key[KEY_ETYPE_MSB:KEY_ETYPE_LSB] = i_dl_ethtype;
    o_key[KEY_VLAN_MSB:KEY_VLAN_LSB]   = i_dl_vlantag;
    o_key[KEY_TOS_MSB:KEY_TOS_LSB]     = i_tos;
    o_key[KEY_PROTO_MSB:KEY_PROTO_LSB] = i_proto;
    o_key[KEY_NWSRC_MSB:KEY_NWSRC_LSB] = i_nw_src;
    o_key[KEY_NWDST_MSB:KEY_NWDST_LSB] = i_nw_dst;
  end

endmodule

// File: rtl/lu_entry_composer.sv
// Joins L2 and L3 parser results into one lookup key and hands it off with valid/ready.
module lu_entry_composer
  import lu_entry_composer_pkg::*;
#(
  parameter int unsigned C_AXIS_LEN_DATA_WIDTH = 16,
  parameter int unsigned C_AXIS_SPT_DATA_WIDTH = 8,
  parameter int unsigned L3_TIMEOUT            = 64
) (
  input  logic                             asclk,
  input  logic                             aresetn,
  input  logic                             dl_done,
  input  logic [C_AXIS_LEN_DATA_WIDTH-1:0] pkt_len,
  input  logic [C_AXIS_SPT_DATA_WIDTH-1:0] src_port,
  input  logic [47:0]                      dl_dst,
  input  logic [47:0]                      dl_src,
  input  logic [15:0]                      dl_ethtype,
  input  logic [15:0]                      dl_vlantag,
  input  logic                             arp_done,
  input  logic [7:0]                       arp_op,
  input  logic [31:0]                      arp_ip_src,
  input  logic [31:0]                      arp_ip_dst,
  input  logic                             ip_tp_done,
  input  logic [5:0]                       ip_tos,
  input  logic [7:0]                       ip_proto,
  input  logic [31:0]                      ip_src,
  input  logic [31:0]                      ip_dst,
  output logic                             compose_done,
  output logic                             lu_req_valid,
  input  logic                             lu_req_ready,
  output logic [LU_ENTRY_WIDTH-1:0]        lu_entry,
  output logic [C_AXIS_LEN_DATA_WIDTH-1:0] lu_pkt_len,
  output logic [31:0]                      entry_cnt,
  output logic [31:0]                      drop_cnt,
  output logic [31:0]                      timeout_cnt
);

  localparam logic [15:0] TMO_LAST = 16'(L3_TIMEOUT - 1);

  composer_state_e r_state, w_state_next;

  logic [C_AXIS_SPT_DATA_WIDTH-1:0] r_src_port;
  logic [C_AXIS_LEN_DATA_WIDTH-1:0] r_pkt_len;
  logic [47:0] r_dl_dst, r_dl_src;
  logic [15:0] r_ethtype, r_vlantag;
  logic [5:0]  r_tos;
  logic [7:0]  r_proto;
  logic [31:0] r_nw_src, r_nw_dst;
  logic        r_expect_arp;
  logic [15:0] r_tcnt;
  logic        r_valid, r_done;
  logic [31:0] r_entry_cnt, r_drop_cnt, r_timeout_cnt;

  logic w_load_l2, w_load_l3, w_clr_l3, w_l3_arp, w_hs, w_timeout, w_drop, w_hit;

  always_comb begin
    w_state_next = r_state;
    w_load_l2    = 1'b0;
    w_load_l3    = 1'b0;
    w_clr_l3     = 1'b0;
    w_l3_arp     = 1'b0;
    w_hs         = 1'b0;
    w_timeout    = 1'b0;
    w_hit        = 1'b0;
    w_drop       = dl_done && (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        if (dl_done) begin
          w_load_l2 = 1'b1;
          if (dl_ethtype == ETH_IPV4 || dl_ethtype == ETH_ARP) begin
            w_l3_arp = (dl_ethtype == ETH_ARP);
            w_hit    = w_l3_arp ? arp_done : ip_tp_done;
            if (w_hit) begin
              w_load_l3    = 1'b1;
              w_state_next = ST_OUTPUT;
            end else begin
              w_clr_l3     = 1'b1;
              w_state_next = ST_WAIT_L3;
            end
          end else begin
            w_clr_l3     = 1'b1;
            w_state_next = ST_OUTPUT;
          end
        end
      end
      ST_WAIT_L3: begin
        // L3 fields were zeroed on entry, so a timeout leaves them as-is.
        w_l3_arp = r_expect_arp;
        w_hit    = r_expect_arp ? arp_done : ip_tp_done;
        if (w_hit) begin
          w_load_l3    = 1'b1;
          w_state_next = ST_OUTPUT;
        end else if (r_tcnt == TMO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (r_valid && lu_req_ready) begin
          w_hs         = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_src_port    <= '0;
      r_pkt_len     <= '0;
      r_dl_dst      <= '0;
      r_dl_src      <= '0;
      r_ethtype     <= '0;
      r_vlantag     <= '0;
      r_tos         <= '0;
      r_proto       <= '0;
      r_nw_src      <= '0;
      r_nw_dst      <= '0;
      r_expect_arp  <= 1'b0;
      r_tcnt        <= '0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_entry_cnt   <= '0;
      r_drop_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= (w_state_next == ST_OUTPUT);
      r_done  <= (w_state_next == ST_DONE);
      if (w_load_l2) begin
        r_src_port   <= src_port;
        r_pkt_len    <= pkt_len;
        r_dl_dst     <= dl_dst;
        r_dl_src     <= dl_src;
        r_ethtype    <= dl_ethtype;
        r_vlantag    <= dl_vlantag;
        r_expect_arp <= (dl_ethtype == ETH_ARP);
        r_tcnt       <= '0;
      end else if (r_state == ST_WAIT_L3) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
      if (w_load_l3) begin
        r_tos    <= w_l3_arp ? 6'd0       : ip_tos;
        r_proto  <= w_l3_arp ? arp_op     : ip_proto;
        r_nw_src <= w_l3_arp ? arp_ip_src : ip_src;
        r_nw_dst <= w_l3_arp ? arp_ip_dst : ip_dst;
      end else if (w_clr_l3) begin
        r_tos    <= '0;
        r_proto  <= '0;
        r_nw_src <= '0;
        r_nw_dst <= '0;
      end
      if (w_hs)      r_entry_cnt   <= r_entry_cnt + 32'd1;
      if (w_drop)    r_drop_cnt    <= r_drop_cnt + 32'd1;
      if (w_timeout) r_timeout_cnt <= r_timeout_cnt + 32'd1;
    end
  end

  lu_entry_composer_key_pack u_key_pack (
    .i_src_port   (8'(r_src_port)),
    .i_dl_dst     (r_dl_dst),
    .i_dl_src     (r_dl_src),
    .i_dl_ethtype (r_ethtype),
    .i_dl_vlantag (r_vlantag),
    .i_tos        (r_tos),
    .i_proto      (r_proto),
    .i_nw_src     (r_nw_src),
    .i_nw_dst     (r_nw_dst),
    .o_key        (lu_entry)
  );

  assign compose_done = r_done;
  assign lu_req_valid = r_valid;
  assign lu_pkt_len   = r_pkt_len;
  assign entry_cnt    = r_entry_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign timeout_cnt  = r_timeout_cnt;

endmodule

// File: tb/tb_lu_entry_composer.sv
// Directed bench for lu_entry_composer: IP, ARP, non-IP, timeout/drop, simultaneous strobes, reset.
module tb_lu_entry_composer;

  logic         asclk = 1'b0;
  logic         aresetn;
  logic         dl_done;
  logic [15:0]  pkt_len;
  logic [7:0]   src_port;
  logic [47:0]  dl_dst, dl_src;
  logic [15:0]  dl_ethtype, dl_vlantag;
  logic         arp_done;
  logic [7:0]   arp_op;
  logic [31:0]  arp_ip_src, arp_ip_dst;
  logic         ip_tp_done;
  logic [5:0]   ip_tos;
  logic [7:0]   ip_proto;
  logic [31:0]  ip_src, ip_dst;
  logic         compose_done, lu_req_valid, lu_req_ready;
  logic [255:0] lu_entry;
  logic [15:0]  lu_pkt_len;
  logic [31:0]  entry_cnt, drop_cnt, timeout_cnt;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [255:0] exp_key;
  logic [255:0] held_key;

  always #5 asclk = ~asclk;

  lu_entry_composer #(
    .C_AXIS_LEN_DATA_WIDTH (16),
    .C_AXIS_SPT_DATA_WIDTH (8),
    .L3_TIMEOUT            (64)
  ) dut (
    .asclk        (asclk),
    .aresetn      (aresetn),
    .dl_done      (dl_done),
    .pkt_len      (pkt_len),
    .src_port     (src_port),
    .dl_dst       (dl_dst),
    .dl_src       (dl_src),
    .dl_ethtype   (dl_ethtype),
    .dl_vlantag   (dl_vlantag),
    .arp_done     (arp_done),
    .arp_op       (arp_op),
    .arp_ip_src   (arp_ip_src),
    .arp_ip_dst   (arp_ip_dst),
    .ip_tp_done   (ip_tp_done),
    .ip_tos       (ip_tos),
    .ip_proto     (ip_proto),
    .ip_src       (ip_src),
    .ip_dst       (ip_dst),
    .compose_done (compose_done),
    .lu_req_valid (lu_req_valid),
    .lu_req_ready (lu_req_ready),
    .lu_entry     (lu_entry),
    .lu_pkt_len   (lu_pkt_len),
    .entry_cnt    (entry_cnt),
    .drop_cnt     (drop_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  task automatic tick();
    @(posedge asclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_l2(input logic [7:0] sp, input logic [47:0] dst, input logic [47:0] src,
                        input logic [15:0] et, input logic [15:0] vl, input logic [15:0] len);
    src_port   = sp;
    dl_dst     = dst;
    dl_src     = src;
    dl_ethtype = et;
    dl_vlantag = vl;
    pkt_len    = len;
  endtask

  initial begin
    aresetn = 1'b0; dl_done = 1'b0; arp_done = 1'b0; ip_tp_done = 1'b0; lu_req_ready = 1'b0;
    set_l2(8'h0, 48'h0, 48'h0, 16'h0, 16'h0, 16'h0);
    arp_op = 8'h0; arp_ip_src = '0; arp_ip_dst = '0;
    ip_tos = '0; ip_proto = '0; ip_src = '0; ip_dst = '0;
    tick(); tick();
    chk("rst_valid", 256'(lu_req_valid), 256'd0);
    chk("rst_done",  256'(compose_done), 256'd0);
    chk("rst_entry", lu_entry, 256'd0);
    chk("rst_cnts",  256'({entry_cnt, drop_cnt, timeout_cnt}), 256'd0);
    aresetn = 1'b1;
    tick();

    // IPv4, ready tied high
    lu_req_ready = 1'b1;
    set_l2(8'h03, 48'h001122334455, 48'h0A0B0C0D0E0F, 16'h0800, 16'h0000, 16'd64);
    dl_done = 1'b1;
    tick();
    dl_done = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ip_wait_valid", 256'(lu_req_valid), 256'd0);
    ip_tp_done = 1'b1; ip_tos = 6'h2E; ip_proto = 8'h06; ip_src = 32'h0A000001; ip_dst = 32'h0A000002;
    tick();
    ip_tp_done = 1'b0;
    chk("ip_valid", 256'(lu_req_valid), 256'd1);
    chk("ip_proto", 256'(lu_entry[113:106]), 256'h06);
    chk("ip_nwsrc", 256'(lu_entry[105:74]), 256'h0A000001);
    chk("ip_spt",   256'(lu_entry[255:248]), 256'h03);
    exp_key = {8'h03, 48'h001122334455, 48'h0A0B0C0D0E0F, 16'h0800, 16'h0000,
               6'h2E, 8'h06, 32'h0A000001, 32'h0A000002, 42'h0};
    chk("ip_key", lu_entry, exp_key);
    chk("ip_len", 256'(lu_pkt_len), 256'd64);
    chk("ip_done_early", 256'(compose_done), 256'd0);
    tick();
    chk("ip_done", 256'(compose_done), 256'd1);
    chk("ip_valid_drop", 256'(lu_req_valid), 256'd0);
    chk("ip_entry_cnt", 256'(entry_cnt), 256'd1);
    tick();
    chk("ip_done_pulse", 256'(compose_done), 256'd0);

    // ARP with backpressure; a stray IP strobe while waiting must be ignored
    lu_req_ready = 1'b0;
    set_l2(8'h05, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 16'h0064, 16'd60);
    dl_done = 1'b1;
    tick();
    dl_done = 1'b0;
    ip_tp_done = 1'b1; ip_proto = 8'h11;
    tick();
    ip_tp_done = 1'b0;
    chk("arp_ignore_ip", 256'(lu_req_valid), 256'd0);
    arp_done = 1'b1; arp_op = 8'h01; arp_ip_src = 32'hC0A80001; arp_ip_dst = 32'hC0A80002;
    tick();
    arp_done = 1'b0;
    exp_key = {8'h05, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 16'h0064,
               6'h00, 8'h01, 32'hC0A80001, 32'hC0A80002, 42'h0};
    chk("arp_key", lu_entry, exp_key);
    held_key = lu_entry;
    for (int i = 0; i < 10; i++) tick();
    chk("arp_hold_valid", 256'(lu_req_valid), 256'd1);
    chk("arp_hold_key", lu_entry, exp_key);
    chk("arp_hold_stable", lu_entry, held_key);
    chk("arp_proto", 256'(lu_entry[113:106]), 256'h01);
    chk("arp_no_done", 256'(compose_done), 256'd0);
    lu_req_ready = 1'b1;
    tick();
    chk("arp_done", 256'(compose_done), 256'd1);
    chk("arp_entry_cnt", 256'(entry_cnt), 256'd2);
    tick();

    // Non-IP ethtype with a coincident IP strobe: L3 must be zero
    lu_req_ready = 1'b0;
    set_l2(8'h02, 48'h665544332211, 48'h0000000000AA, 16'h86DD, 16'h0000, 16'd80);
    dl_done = 1'b1; ip_tp_done = 1'b1; ip_tos = 6'h3F; ip_proto = 8'hFF;
    tick();
    dl_done = 1'b0; ip_tp_done = 1'b0;
    chk("v6_valid", 256'(lu_req_valid), 256'd1);
    chk("v6_l3_zero", 256'(lu_entry[119:42]), 256'd0);
    exp_key = {8'h02, 48'h665544332211, 48'h0000000000AA, 16'h86DD, 16'h0000, 120'h0};
    chk("v6_key", lu_entry, exp_key);
    lu_req_ready = 1'b1;
    tick();
    chk("v6_done", 256'(compose_done), 256'd1);
    tick();

    // L3 strobes in IDLE without dl_done
    arp_done = 1'b1; ip_tp_done = 1'b1;
    tick();
    arp_done = 1'b0; ip_tp_done = 1'b0;
    tick();
    chk("idle_strobe_ignored", 256'(lu_req_valid), 256'd0);
    chk("idle_entry_cnt", 256'(entry_cnt), 256'd3);

    // Timeout with a dropped dl_done in WAIT_L3
    lu_req_ready = 1'b0;
    set_l2(8'h07, 48'h111111111111, 48'h222222222222, 16'h0800, 16'h0000, 16'd100);
    dl_done = 1'b1;
    tick();
    dl_done = 1'b0;
    tick(); tick();
    set_l2(8'h09, 48'h333333333333, 48'h444444444444, 16'h86DD, 16'h0001, 16'd200);
    dl_done = 1'b1;
    tick();
    dl_done = 1'b0;
    chk("drop_cnt", 256'(drop_cnt), 256'd1);
    for (int i = 0; i < 60; i++) tick();
    chk("tmo_not_yet", 256'(lu_req_valid), 256'd0);
    tick();
    chk("tmo_valid", 256'(lu_req_valid), 256'd1);
    chk("tmo_cnt", 256'(timeout_cnt), 256'd1);
    exp_key = {8'h07, 48'h111111111111, 48'h222222222222, 16'h0800, 16'h0000, 120'h0};
    chk("tmo_key", lu_entry, exp_key);
    chk("tmo_len", 256'(lu_pkt_len), 256'd100);
    lu_req_ready = 1'b1;
    tick();
    chk("tmo_done", 256'(compose_done), 256'd1);
    chk("tmo_entry_cnt", 256'(entry_cnt), 256'd4);
    tick();

    // Simultaneous dl_done/ip_tp_done, then reset while in OUTPUT
    lu_req_ready = 1'b0;
    set_l2(8'h01, 48'hAABBCCDDEEFF, 48'h001122334455, 16'h0800, 16'h2005, 16'd1500);
    dl_done = 1'b1; ip_tp_done = 1'b1;
    ip_tos = 6'h01; ip_proto = 8'h11; ip_src = 32'h01020304; ip_dst = 32'h05060708;
    tick();
    dl_done = 1'b0; ip_tp_done = 1'b0;
    chk("sim_valid", 256'(lu_req_valid), 256'd1);
    exp_key = {8'h01, 48'hAABBCCDDEEFF, 48'h001122334455, 16'h0800, 16'h2005,
               6'h01, 8'h11, 32'h01020304, 32'h05060708, 42'h0};
    chk("sim_key", lu_entry, exp_key);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_valid", 256'(lu_req_valid), 256'd0);
    chk("arst_entry", lu_entry, 256'd0);
    chk("arst_cnts", 256'({entry_cnt, drop_cnt, timeout_cnt}), 256'd0);
    lu_req_ready = 1'b1;
    tick();
    chk("arst_no_done", 256'(compose_done), 256'd0);
    #2;
    aresetn = 1'b1;
    tick();
    chk("post_rst_done", 256'(compose_done), 256'd0);
    chk("post_rst_valid", 256'(lu_req_valid), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
